// File: rtl/mac_accum.sv
// mac_accum: signed 8x8 multiply-accumulate neuron stage.
// Loads a bias, sums VEC_LEN act*wgt products, then emits a rescaled
// 16-bit result with a one-cycle OUT_VALID pulse.
//
// Ports:
//   CLKEXT    clock, rising edge
//   RST       synchronous reset, active-high
//   START     begin a neuron (sampled in IDLE only)
//   BIAS_IN   signed bias in product scale, sampled with START
//   VEC_LEN   beat count, sampled with START (0 = bias-only)
//   IN_VALID  ACT_IN/WGT_IN carry a beat this cycle
//   ACT_IN    signed activation
//   WGT_IN    signed weight
//   BUSY      high while accumulating or emitting
//   OUT_VALID one-cycle pulse when MAC_OUT is updated
//   MAC_OUT   signed result, held until the next one
//
// Build option: MAC_SATURATE_EN clamps the result to the signed
// 16-bit range; without it the result wraps (low 16 bits).

module mac_accum #(
  parameter int ACC_W      = 26,
  parameter int VEC_LEN_W  = 10,
  parameter int FRAC_SHIFT = 7
) (
  input  logic                 CLKEXT,
  input  logic                 RST,
  input  logic                 START,
  input  logic [15:0]          BIAS_IN,
  input  logic [VEC_LEN_W-1:0] VEC_LEN,
  input  logic                 IN_VALID,
  input  logic [7:0]           ACT_IN,
  input  logic [7:0]           WGT_IN,
  output logic                 BUSY,
  output logic                 OUT_VALID,
  output logic [15:0]          MAC_OUT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_OUTPUT
  } state_e;

  state_e                 state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [VEC_LEN_W-1:0]   cnt_q;
  logic [VEC_LEN_W-1:0]   len_q;
  logic                   busy_q;
  logic                   out_valid_q;
  logic [15:0]            mac_q;

  logic signed [15:0]      prod_d;
  logic signed [ACC_W-1:0] prod_ext_d;
  logic signed [ACC_W-1:0] bias_ext_d;
  logic                    last_beat_d;
  logic [15:0]             fit_d;

  // 16x16 on sign-extended operands; the low 16 bits are the exact
  // signed 8x8 product.
  assign prod_d = $signed({{8{ACT_IN[7]}}, ACT_IN})
                * $signed({{8{WGT_IN[7]}}, WGT_IN});

  assign prod_ext_d = {{(ACC_W-16){prod_d[15]}}, prod_d};
  assign bias_ext_d = {{(ACC_W-16){BIAS_IN[15]}}, BIAS_IN};

  assign last_beat_d = (cnt_q == len_q - VEC_LEN_W'(1));

`ifdef MAC_SATURATE_EN
  logic signed [ACC_W-1:0] shr_d;
  logic                    fits_d;

  // Floor shift; the value fits when every bit above bit 15
  // matches bit 15.
  assign shr_d  = acc_q >>> FRAC_SHIFT;
  assign fits_d = (shr_d[ACC_W-1:15] == {(ACC_W-15){shr_d[15]}});

  always_comb begin
    fit_d = shr_d[15:0];
    if (!fits_d) begin
      fit_d = shr_d[ACC_W-1] ? 16'h8000 : 16'h7FFF;
    end
  end
`else
  // Low 16 bits of the arithmetic shift are just a slice of acc.
  assign fit_d = acc_q[FRAC_SHIFT +: 16];
`endif

  always_ff @(posedge CLKEXT) begin
    if (RST) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      mac_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (START) begin
            acc_q  <= bias_ext_d;
            cnt_q  <= '0;
            len_q  <= VEC_LEN;
            busy_q <= 1'b1;
            if (VEC_LEN == '0) begin
              state_q <= S_OUTPUT;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (IN_VALID) begin
            acc_q <= acc_q + prod_ext_d;
            cnt_q <= cnt_q + VEC_LEN_W'(1);
            if (last_beat_d) begin
              state_q <= S_OUTPUT;
            end
          end
        end
        S_OUTPUT: begin
          mac_q       <= fit_d;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign BUSY      = busy_q;
  assign OUT_VALID = out_valid_q;
  assign MAC_OUT   = mac_q;

endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: directed bench for mac_accum with a sum-of-products
// reference model and a per-cycle output scoreboard.

module tb_mac_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bias;
  logic [9:0]  vlen;
  logic        in_valid;
  logic [7:0]  act;
  logic [7:0]  wgt;
  logic        busy;
  logic        ov;
  logic [15:0] mac;

  always #5 clk = ~clk;

  mac_accum dut (
    .CLKEXT   (clk),
    .RST      (rst),
    .START    (start),
    .BIAS_IN  (bias),
    .VEC_LEN  (vlen),
    .IN_VALID (in_valid),
    .ACT_IN   (act),
    .WGT_IN   (wgt),
    .BUSY     (busy),
    .OUT_VALID(ov),
    .MAC_OUT  (mac)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  logic [15:0] hold;
  logic [15:0] ce;
  logic        prev_ov;
  longint      m_sum;

  always @(posedge clk) cyc++;

  task automatic check(string name, longint got, longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, got, want, cyc);
    end
  endtask

  // Reference: floor(sum / 2^7), then fit to 16 bits.
  function automatic logic [15:0] fit(longint s);
    longint q;
    q = (s >= 0) ? s / 128 : -((-s + 127) / 128);
`ifdef MAC_SATURATE_EN
    if (q > 32767) return 16'h7FFF;
    if (q < -32768) return 16'h8000;
`endif
    return q[15:0];
  endfunction

  // Per-cycle scoreboard: every pulse must carry the next expected
  // result; between pulses MAC_OUT must hold.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (ov) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          ce = exp_q.pop_front();
          check("mac_out_model", mac, ce);
          hold = ce;
        end
      end else begin
        check("mac_out_hold", mac, hold);
      end
      check("out_valid_pulse", prev_ov & ov, 0);
      prev_ov = ov;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    hold = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_out_valid", ov, 0);
    check("rst_mac_out", mac, 0);
    rst = 1'b0;
  endtask

  task automatic start_neuron(logic [15:0] b, int len);
    start = 1'b1;
    bias = b;
    vlen = len[9:0];
    m_sum = longint'($signed(b));
    @(negedge clk);
    start = 1'b0;
    bias = 16'hDEAD;
    vlen = 10'h3FF;
    check("busy_after_start", busy, 1);
  endtask

  task automatic feed(int a, int w, int gap);
    repeat (gap) begin
      in_valid = 1'b0;
      act = 8'($urandom);
      wgt = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    act = a[7:0];
    wgt = w[7:0];
    m_sum += longint'(a * w);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_result();
    exp_q.push_back(fit(m_sum));
  endtask

  task automatic wait_out(logic [15:0] lit, string name, output int t);
    int n;
    n = 0;
    while (n < 12) begin
      @(negedge clk);
      n++;
      if (ov) break;
    end
    check({"latency_", name}, n, 1);
    check(name, mac, lit);
    check({"busy_idle_", name}, busy, 0);
    t = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, ta, tb;
    rst = 1'b1;
    start = 1'b0;
    bias = '0;
    vlen = '0;
    in_valid = 1'b0;
    act = '0;
    wgt = '0;
    hold = '0;
    prev_ov = 1'b0;
    do_reset();

    // basic: 4 x 64*64 = 16384 -> 128
    start_neuron(16'h0000, 4);
    repeat (4) feed(64, 64, 0);
    expect_result();
    wait_out(16'h0080, "basic", t);

    // negative: -3 floors to -1
    start_neuron(16'h0000, 3);
    repeat (3) feed(-1, 1, 0);
    expect_result();
    wait_out(16'hFFFF, "negative", t);
    check("relu_out", mac[15] ? 16'h0000 : mac, 0);

    // stalls between beats: same as basic
    start_neuron(16'h0000, 4);
    feed(64, 64, 0);
    feed(64, 64, 0);
    feed(64, 64, 3);
    feed(64, 64, 1);
    expect_result();
    wait_out(16'h0080, "stall", t);

    // bias only: 256 -> 2
    start_neuron(16'h0100, 0);
    expect_result();
    wait_out(16'h0002, "bias_only", t);

    // mixed signs: -200-5000+16384+381 = 11565 -> 90
    start_neuron(16'hFF38, 3);
    feed(100, -50, 0);
    feed(-128, -128, 2);
    feed(127, 3, 0);
    expect_result();
    wait_out(16'h005A, "mixed", t);

    // -16256-128 = -16384 -> -128
    start_neuron(16'h0000, 2);
    feed(-128, 127, 0);
    feed(-128, 1, 0);
    expect_result();
    wait_out(16'hFF80, "neg_exact", t);

    // reset after 2 of 4 beats discards the neuron
    start_neuron(16'h0000, 4);
    feed(64, 64, 0);
    feed(64, 64, 0);
    do_reset();
    repeat (4) @(negedge clk);
    check("busy_after_abort", busy, 0);
    start_neuron(16'h0000, 4);
    repeat (4) feed(64, 64, 0);
    expect_result();
    wait_out(16'h0080, "fresh_after_rst", t);

    // START while busy is ignored; IN_VALID in OUTPUT is ignored
    start_neuron(16'h0000, 4);
    feed(64, 64, 0);
    start = 1'b1;
    bias = 16'h7FFF;
    vlen = 10'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) feed(64, 64, 0);
    in_valid = 1'b1;
    act = 8'd127;
    wgt = 8'd127;
    expect_result();
    wait_out(16'h0080, "start_busy", t);
    in_valid = 1'b0;

    // back-to-back: START in the cycle OUT_VALID is high
    start_neuron(16'h0000, 3);
    repeat (3) feed(10, 20, 0);
    expect_result();
    wait_out(16'h0004, "b2b_first", ta);
    start_neuron(16'h0040, 5);
    repeat (5) feed(-7, 9, 0);
    expect_result();
    wait_out(16'hFFFE, "b2b_second", tb);
    check("b2b_period", tb - ta, 7);

    // 784 x 127*127 = 12645136 -> 98790
    start_neuron(16'h0000, 784);
    repeat (784) feed(127, 127, 0);
    expect_result();
`ifdef MAC_SATURATE_EN
    wait_out(16'h7FFF, "saturate", t);
`else
    wait_out(16'h81E6, "wrap", t);
`endif

    repeat (3) @(negedge clk);
    check("results_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
